zap_ptw_arbiter: RTL and testbench
==================================

Name: zap_ptw_arbiter

Overview:
- Shares the single page-table-walk Wishbone master between the instruction-side and data-side TLB walkers. Each walker drives the arbiter with its next-cycle Wishbone request signals.
- Grants the bus to one walker for a whole cyc burst, registers the winner's signals onto the shared port, and steers ack back to the owner only.
- Sits between the two TLB instances and the core's external Wishbone OR-mux.

Parameters:
- TIMEOUT_CYCLES, 256, ack watchdog limit in cycles (used only with the optional feature); legal range 2..65535.
- FIRST_TIE_D, 1, tie-break winner on the first simultaneous request after reset (1 = D-side, 0 = I-side).

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_i_wb_cyc_nxt, i_i_wb_stb_nxt, i_i_wb_wen_nxt  in  1 each  I-walker next-cycle cyc/stb/wen.
- i_i_wb_adr_nxt  in  32  I-walker address.
- i_i_wb_sel_nxt  in  4  I-walker byte selects.
- i_d_wb_cyc_nxt, i_d_wb_stb_nxt, i_d_wb_wen_nxt  in  1 each  D-walker next-cycle cyc/stb/wen.
- i_d_wb_adr_nxt  in  32  D-walker address.
- i_d_wb_sel_nxt  in  4  D-walker byte selects.
- o_i_gnt, o_d_gnt  out  1 each  walker currently owns the bus.
- o_i_ack, o_d_ack  out  1 each  ack routed to the owner.
- o_i_err, o_d_err  out  1 each  watchdog abort pulse.
- o_wb_dat  out  32  read data, i_wb_dat broadcast unchanged to both walkers.
- o_wb_cyc, o_wb_stb, o_wb_wen  out  1 each  shared bus, registered.
- o_wb_adr  out  32  shared bus address, registered.
- o_wb_sel  out  4  shared bus byte selects, registered.
- i_wb_dat  in  32  bus read data.
- i_wb_ack  in  1  bus ack.

Behaviour:
- Reset (async, i_reset_n=0):
  - state = IDLE; last_owner = I when FIRST_TIE_D=1, otherwise D.
  - o_wb_cyc/stb/wen = 0; o_wb_adr = 0; o_wb_sel = 0.
  - All gnt/ack/err outputs = 0; watchdog counter = 0.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - If exactly one walker has cyc_nxt=1, move to that walker's GNT state.
  - If both do, grant the walker that is not last_owner.
  - On the grant edge, register the winner's cyc/stb/wen/adr/sel onto o_wb_*.
  - Grant latency: one cycle from cyc_nxt to o_wb_cyc.
- GNT_x:
  - Every cycle, o_wb_* registers owner x's *_nxt inputs.
  - o_x_gnt = 1, driven from the state register.
  - o_x_ack = i_wb_ack, combinational, owner only. The non-owner's ack is always 0.
  - Any ack arriving in IDLE is dropped.
- Release: when the owner's cyc_nxt=0, the next edge clears o_wb_cyc and o_wb_stb, sets last_owner = x, and moves to IDLE.
  - One mandatory IDLE bubble cycle between owners; no back-to-back handover.
- Non-owner protocol: a walker without the grant holds its *_nxt stable until o_x_gnt=1. The arbiter never drops a pending request.
- Simultaneous events:
  - Release and a new request from the same walker in one cycle: the release wins; the walker is re-arbitrated from IDLE.
  - Ack in the same cycle as a release: forwarded to the owner.
- Reset mid-burst: the bus drops immediately (async); no ack or err is issued afterwards.
- The arbiter never alters adr/sel/wen contents; widths pass through 1:1.

Optional Feature:
- Macro: ZAP_PTW_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on grant and on each ack, and increments each GNT cycle with o_wb_stb=1 and i_wb_ack=0.
  - When the count reaches TIMEOUT_CYCLES-1 with still no ack, the next edge forces o_wb_cyc/stb = 0, pulses o_x_err for exactly one cycle, sets last_owner = x, and moves to IDLE.
  - An ack on the terminal cycle takes priority over the abort.
- Undefined: no counter is built; o_i_err and o_d_err are tied to 0.

Decomposition:
- Shared package zap_ptw_arb_pkg holds:
  - the state enum (IDLE/GNT_I/GNT_D);
  - a packed typedef zap_ptw_req_t {cyc, stb, wen, adr[31:0], sel[3:0]};
  - the requester-id constants REQ_I=0, REQ_D=1.
- Sub-module zap_ptw_arb_pick: combinational 2-way round-robin picker (req[1:0], last_owner) -> winner. It is reused later for a 4-way version.

Test Plan:
- Lone D request, adr=0x0000_4000, held 3 cycles, ack on the 3rd bus cycle -> o_wb_cyc=1 one cycle after cyc_nxt; o_wb_adr=0x4000; o_d_ack=1 with o_i_ack=0; IDLE one cycle after release.
- Both request in the first cycle after reset with FIRST_TIE_D=1 -> D granted (adr 0x8000). After D releases, one IDLE bubble, then I granted (adr 0xC000). A second tie then goes to I (last_owner=D).
- I owns the bus; D requests mid-burst -> o_d_gnt stays 0 and o_d_ack stays 0 on all 4 acks to I. D is granted two cycles after I's cyc_nxt falls.
- Assert i_reset_n=0 during a GNT_D burst -> o_wb_cyc=0 asynchronously, all gnt=0. After release, a lone I request is granted normally.
- With ZAP_PTW_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, D stb held and no ack -> o_wb_cyc drops and o_d_err pulses exactly 1 cycle, 8 cycles after stb. An ack at count 7 -> no err.
- Stray i_wb_ack=1 in IDLE -> o_i_ack=o_d_ack=0, state stays IDLE.

Source files
------------

// File: rtl/zap_ptw_arb_pkg.sv
// Shared types and constants for the page-table-walk arbiter slice.
package zap_ptw_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } zap_ptw_state_t;

    // One walker's next-cycle Wishbone request, bundled for the bus register.
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  sel;
    } zap_ptw_req_t;

    // Requester ids; also used as bit positions in request vectors.
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/zap_ptw_arb_pick.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes
// to whichever requester did not own the bus last.
import zap_ptw_arb_pkg::*;

module zap_ptw_arb_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner
);

    // Pick the winner for the current request vector.
    always_comb begin
        winner = REQ_I;
        if (req == 2'b11) begin
            winner = ~last_owner;
        end else if (req[REQ_D]) begin
            winner = REQ_D;
        end
    end

endmodule

// File: rtl/zap_ptw_arbiter.sv
// Page-table-walk Wishbone arbiter between the I-side and D-side TLB walkers.
// Grants the shared master for a whole cyc burst, registers the owner's
// next-cycle request onto the bus and routes ack to the owner only.
// Optional ack watchdog: define ZAP_PTW_ARB_TIMEOUT_EN.
import zap_ptw_arb_pkg::*;

module zap_ptw_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter bit FIRST_TIE_D    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_i_wb_cyc_nxt,
    input  logic        i_i_wb_stb_nxt,
    input  logic        i_i_wb_wen_nxt,
    input  logic [31:0] i_i_wb_adr_nxt,
    input  logic [3:0]  i_i_wb_sel_nxt,

    input  logic        i_d_wb_cyc_nxt,
    input  logic        i_d_wb_stb_nxt,
    input  logic        i_d_wb_wen_nxt,
    input  logic [31:0] i_d_wb_adr_nxt,
    input  logic [3:0]  i_d_wb_sel_nxt,

    output logic        o_i_gnt,
    output logic        o_d_gnt,
    output logic        o_i_ack,
    output logic        o_d_ack,
    output logic        o_i_err,
    output logic        o_d_err,
    output logic [31:0] o_wb_dat,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,

    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack
);

    zap_ptw_state_t state;
    zap_ptw_req_t   i_req;
    zap_ptw_req_t   d_req;
    zap_ptw_req_t   win_req;
    zap_ptw_req_t   own_req;
    zap_ptw_req_t   bus;
    logic           last_owner;
    logic           winner;
    logic           owner_id;
    logic           in_gnt;
    logic           release_now;
    logic           abort;

    assign i_req = {i_i_wb_cyc_nxt, i_i_wb_stb_nxt, i_i_wb_wen_nxt,
                    i_i_wb_adr_nxt, i_i_wb_sel_nxt};
    assign d_req = {i_d_wb_cyc_nxt, i_d_wb_stb_nxt, i_d_wb_wen_nxt,
                    i_d_wb_adr_nxt, i_d_wb_sel_nxt};

    zap_ptw_arb_pick u_pick (
        .req        ({i_d_wb_cyc_nxt, i_i_wb_cyc_nxt}),
        .last_owner (last_owner),
        .winner     (winner)
    );

    assign win_req     = (winner == REQ_D) ? d_req : i_req;
    assign in_gnt      = (state == GNT_I) || (state == GNT_D);
    assign owner_id    = (state == GNT_D) ? REQ_D : REQ_I;
    assign own_req     = (owner_id == REQ_D) ? d_req : i_req;
    assign release_now = in_gnt && !own_req.cyc;

`ifdef ZAP_PTW_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wdog;
    logic        i_err_q;
    logic        d_err_q;

    // Abort only a burst that is still asserted; an ack this cycle wins.
    assign abort = in_gnt && own_req.cyc && bus.stb && !i_wb_ack && (wdog == TO_LAST);

    // Ack watchdog: idle-time clear doubles as the clear-on-grant.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wdog <= '0;
        end else if (!in_gnt || i_wb_ack) begin
            wdog <= '0;
        end else if (bus.stb) begin
            wdog <= wdog + 16'd1;
        end
    end

    // One-cycle error pulse to the aborted owner.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            i_err_q <= 1'b0;
            d_err_q <= 1'b0;
        end else begin
            i_err_q <= abort && (owner_id == REQ_I);
            d_err_q <= abort && (owner_id == REQ_D);
        end
    end

    assign o_i_err = i_err_q;
    assign o_d_err = d_err_q;
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign abort          = 1'b0;
    assign o_i_err        = 1'b0;
    assign o_d_err        = 1'b0;
`endif

    // Grant FSM and shared bus register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            last_owner <= FIRST_TIE_D ? REQ_I : REQ_D;
            bus        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_i_wb_cyc_nxt || i_d_wb_cyc_nxt) begin
                        state <= (winner == REQ_D) ? GNT_D : GNT_I;
                        bus   <= win_req;
                    end
                end
                GNT_I, GNT_D: begin
                    if (release_now || abort) begin
                        state      <= IDLE;
                        last_owner <= owner_id;
                        bus.cyc    <= 1'b0;
                        bus.stb    <= 1'b0;
                    end else begin
                        bus <= own_req;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus.cyc <= 1'b0;
                    bus.stb <= 1'b0;
                end
            endcase
        end
    end

    assign o_i_gnt  = (state == GNT_I);
    assign o_d_gnt  = (state == GNT_D);
    assign o_i_ack  = (state == GNT_I) && i_wb_ack;
    assign o_d_ack  = (state == GNT_D) && i_wb_ack;
    assign o_wb_dat = i_wb_dat;

    assign o_wb_cyc = bus.cyc;
    assign o_wb_stb = bus.stb;
    assign o_wb_wen = bus.wen;
    assign o_wb_adr = bus.adr;
    assign o_wb_sel = bus.sel;

endmodule

// File: tb/tb_zap_ptw_arbiter.sv
// Self-checking bench for zap_ptw_arbiter: directed scenarios followed by
// randomized walker traffic, all checked against a behavioural owner model.
// Watchdog scenarios are included when ZAP_PTW_ARB_TIMEOUT_EN is defined.
module tb_zap_ptw_arbiter;

    localparam int TO = 8;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [31:0] i_wb_dat = '0;
    logic        i_wb_ack = 1'b0;

    // Walker request inputs, index 0 = I-side, 1 = D-side.
    logic        cyc [2];
    logic        stb [2];
    logic        wen [2];
    logic [31:0] adr [2];
    logic [3:0]  sel [2];

    logic        o_i_gnt, o_d_gnt, o_i_ack, o_d_ack, o_i_err, o_d_err;
    logic [31:0] o_wb_dat;
    logic        o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [31:0] o_wb_adr;
    logic [3:0]  o_wb_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus and what the bus should carry.
    int          owner;      // -1 none, 0 I, 1 D
    int          last;
    int          wait_cnt;
    int          err_who;
    logic        cur_ack;
    logic        exp_cyc, exp_stb, exp_wen;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;

    // Random walker agents.
    bit want [2];
    int left [2];

    zap_ptw_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .FIRST_TIE_D    (1'b1)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_i_wb_cyc_nxt (cyc[0]),
        .i_i_wb_stb_nxt (stb[0]),
        .i_i_wb_wen_nxt (wen[0]),
        .i_i_wb_adr_nxt (adr[0]),
        .i_i_wb_sel_nxt (sel[0]),
        .i_d_wb_cyc_nxt (cyc[1]),
        .i_d_wb_stb_nxt (stb[1]),
        .i_d_wb_wen_nxt (wen[1]),
        .i_d_wb_adr_nxt (adr[1]),
        .i_d_wb_sel_nxt (sel[1]),
        .o_i_gnt        (o_i_gnt),
        .o_d_gnt        (o_d_gnt),
        .o_i_ack        (o_i_ack),
        .o_d_ack        (o_d_ack),
        .o_i_err        (o_i_err),
        .o_d_err        (o_d_err),
        .o_wb_dat       (o_wb_dat),
        .o_wb_cyc       (o_wb_cyc),
        .o_wb_stb       (o_wb_stb),
        .o_wb_wen       (o_wb_wen),
        .o_wb_adr       (o_wb_adr),
        .o_wb_sel       (o_wb_sel),
        .i_wb_dat       (i_wb_dat),
        .i_wb_ack       (i_wb_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int w, input logic c, input logic s, input logic wn,
                           input logic [31:0] a, input logic [3:0] se);
        cyc[w] = c;
        stb[w] = s;
        wen[w] = wn;
        adr[w] = a;
        sel[w] = se;
    endtask

    task automatic load(input int w);
        exp_cyc = cyc[w];
        exp_stb = stb[w];
        exp_wen = wen[w];
        exp_adr = adr[w];
        exp_sel = sel[w];
    endtask

    task automatic check_outputs();
        check("i_gnt", 32'(o_i_gnt), 32'(owner == 0));
        check("d_gnt", 32'(o_d_gnt), 32'(owner == 1));
        check("wb_cyc", 32'(o_wb_cyc), 32'(exp_cyc));
        check("wb_stb", 32'(o_wb_stb), 32'(exp_stb));
        check("wb_wen", 32'(o_wb_wen), 32'(exp_wen));
        check("wb_adr", o_wb_adr, exp_adr);
        check("wb_sel", 32'(o_wb_sel), 32'(exp_sel));
        check("i_ack", 32'(o_i_ack), 32'(cur_ack && owner == 0));
        check("d_ack", 32'(o_d_ack), 32'(cur_ack && owner == 1));
        check("i_err", 32'(o_i_err), 32'(err_who == 0));
        check("d_err", 32'(o_d_err), 32'(err_who == 1));
        check("wb_dat", o_wb_dat, i_wb_dat);
    endtask

    // Advance one clock: predict the post-edge state, then apply this
    // cycle's ack/data and compare.
    task automatic tick(input logic ack, input logic [31:0] dat);
        int nxt;
        err_who = -1;
        if (owner < 0) begin
            if (cyc[0] && cyc[1]) nxt = (last == 0) ? 1 : 0;
            else if (cyc[1])      nxt = 1;
            else if (cyc[0])      nxt = 0;
            else                  nxt = -1;
            if (nxt >= 0) begin
                owner    = nxt;
                wait_cnt = 0;
                load(nxt);
            end
        end else if (!cyc[owner]) begin
            last    = owner;
            owner   = -1;
            exp_cyc = 1'b0;
            exp_stb = 1'b0;
        end
`ifdef ZAP_PTW_ARB_TIMEOUT_EN
        else if (!cur_ack && exp_stb && wait_cnt == TO - 1) begin
            err_who = owner;
            last    = owner;
            owner   = -1;
            exp_cyc = 1'b0;
            exp_stb = 1'b0;
        end
`endif
        else begin
            if (cur_ack)      wait_cnt = 0;
            else if (exp_stb) wait_cnt++;
            load(owner);
        end
        @(posedge i_clk);
        #1;
        i_wb_ack = ack;
        i_wb_dat = dat;
        cur_ack  = ack;
        #1;
        check_outputs();
    endtask

    // Asynchronous reset applied mid-cycle; outputs must drop at once.
    task automatic do_reset();
        @(posedge i_clk);
        #3;
        i_reset_n = 1'b0;
        i_wb_ack  = 1'b1;
        for (int w = 0; w < 2; w++) begin
            set_req(w, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
            want[w] = 1'b0;
            left[w] = 0;
        end
        owner    = -1;
        last     = 0;
        wait_cnt = 0;
        err_who  = -1;
        cur_ack  = 1'b1;
        exp_cyc  = 1'b0;
        exp_stb  = 1'b0;
        exp_wen  = 1'b0;
        exp_adr  = '0;
        exp_sel  = '0;
        #1;
        check_outputs();
        i_wb_ack = 1'b0;
        cur_ack  = 1'b0;
        #2;
        i_reset_n = 1'b1;
    endtask

    initial begin
        for (int w = 0; w < 2; w++) set_req(w, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        do_reset();

        // Lone D request held three cycles, ack on the third bus cycle.
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h0000_4000, 4'hF);
        tick(1'b0, 32'h1111_0000);
        check("lone_d_adr", o_wb_adr, 32'h0000_4000);
        tick(1'b0, 32'h1111_0001);
        tick(1'b1, 32'h1111_0002);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 4'hF);
        tick(1'b0, 32'h0);
        tick(1'b0, 32'h0);

        // Tie right after reset goes to D, then a tie in the bubble goes to I.
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h0000_C000, 4'hF);
        set_req(1, 1'b1, 1'b1, 1'b1, 32'h0000_8000, 4'h3);
        tick(1'b0, 32'h0);
        check("tie1_d_gnt", 32'(o_d_gnt), 32'd1);
        tick(1'b1, 32'hAAAA_5555);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0000_8000, 4'h3);
        tick(1'b0, 32'h0);
        set_req(1, 1'b1, 1'b1, 1'b1, 32'h0000_8004, 4'h3);
        tick(1'b0, 32'h0);
        check("tie2_i_adr", o_wb_adr, 32'h0000_C000);
        tick(1'b1, 32'h1234_5678);
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0000_C000, 4'hF);
        tick(1'b0, 32'h0);
        tick(1'b0, 32'h0);
        tick(1'b1, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0000_8004, 4'h3);
        tick(1'b0, 32'h0);
        tick(1'b0, 32'h0);

        // I owns, D requests mid-burst and waits through four acks to I.
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 4'hF);
        tick(1'b0, 32'h0);
        set_req(1, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 4'hC);
        for (int k = 0; k < 4; k++) tick(1'b1, 32'(k));
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 4'hF);
        tick(1'b0, 32'h0);
        tick(1'b0, 32'h0);
        check("mid_d_gnt", 32'(o_d_gnt), 32'd1);
        tick(1'b1, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 4'hC);
        tick(1'b0, 32'h0);

        // Reset during a D burst, then a lone I request.
        tick(1'b0, 32'h0);
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 4'hF);
        tick(1'b0, 32'h0);
        tick(1'b1, 32'h0);
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h0000_5000, 4'hF);
        tick(1'b0, 32'h0);
        tick(1'b1, 32'h0);
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0000_5000, 4'hF);
        tick(1'b0, 32'h0);

        // Stray ack while idle.
        tick(1'b1, 32'hDEAD_BEEF);
        tick(1'b1, 32'h0);
        tick(1'b0, 32'h0);

`ifdef ZAP_PTW_ARB_TIMEOUT_EN
        // Watchdog abort with no ack, then an ack on the terminal cycle.
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h0000_6000, 4'hF);
        tick(1'b0, 32'h0);
        for (int k = 0; k < 8; k++) tick(1'b0, 32'h0);
        check("to_d_err", 32'(o_d_err), 32'd1);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0000_6000, 4'hF);
        tick(1'b0, 32'h0);
        tick(1'b0, 32'h0);
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h0000_7000, 4'hF);
        tick(1'b0, 32'h0);
        for (int k = 0; k < 6; k++) tick(1'b0, 32'h0);
        tick(1'b1, 32'h0);
        for (int k = 0; k < 3; k++) tick(1'b0, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0000_7000, 4'hF);
        tick(1'b0, 32'h0);
        tick(1'b0, 32'h0);
`endif

        // Randomized walker traffic.
        for (int k = 0; k < 1500; k++) begin
            for (int w = 0; w < 2; w++) begin
                if (!want[w]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        want[w] = 1'b1;
                        left[w] = int'($urandom_range(1, 5));
                        set_req(w, 1'b1, 1'b1, 1'($urandom_range(0, 1)),
                                $urandom() & 32'hFFFF_FFFC, 4'($urandom_range(1, 15)));
                    end else begin
                        cyc[w] = 1'b0;
                        stb[w] = 1'b0;
                    end
                end else if (owner == w) begin
                    if (left[w] == 0) begin
                        want[w] = 1'b0;
                        cyc[w]  = 1'b0;
                        stb[w]  = 1'b0;
                    end else begin
                        left[w]--;
                        stb[w] = 1'($urandom_range(0, 1));
                        adr[w] = adr[w] + 32'd4;
                    end
                end
            end
            tick(1'($urandom_range(0, 1)), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
